sha1_stream: RTL

Parametrised, streaming SHA-1 compression engine for the ECDSA datapath. Pre-padded 512-bit message blocks are pushed into an internal circular block buffer. On `start`, a multi-block digest runs, consuming blocks as they arrive, so the host can keep writing while hashing is in progress. Rounds per cycle are configurable to trade area for latency. The 160-bit digest feeds the ECDSA scalar stage.

---
 rtl/sha1_stream.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sha1_stream.sv
`default_nettype none
// ============================================================================
// Module      : sha1_stream
// Description : Streaming multi-block SHA-1 engine fed from a circular buffer
//               of pre-padded 512-bit blocks; UNROLL rounds per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sha1_stream #(
    parameter int BUF_DEPTH = 4,
    parameter int UNROLL    = 1,
    parameter int CNT_W     = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CNT_W-1:0]               block_num,
    input  logic                           w_en,
    input  logic [511:0]                   msg,
    output logic                           full,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level,
    output logic                           busy,
    output logic                           done,
    output logic [159:0]                   hash,
    output logic                           overflow
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_LVL_W = $clog2(BUF_DEPTH + 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_ROUND  = 3'd2;
    localparam logic [2:0] c_ST_UPDATE = 3'd3;
    localparam logic [2:0] c_ST_WAIT   = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    localparam logic [159:0] c_IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [6:0]   c_LAST_STEP = 7'(80 - UNROLL);

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] f_fn(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)      return (b & c) | (~b & d);
        else if (t < 7'd40) return b ^ c ^ d;
        else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] k_fn(input logic [6:0] t);
        if (t < 7'd20)      return 32'h5a827999;
        else if (t < 7'd40) return 32'h6ed9eba1;
        else if (t < 7'd60) return 32'h8f1bbcdc;
        else                return 32'hca62c1d6;
    endfunction

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [511:0]       r_mem [BUF_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_count;
    logic               r_overflow;
    logic [159:0]       r_hash;
    logic [31:0]        r_h [5];
    logic [31:0]        r_a, r_b, r_c, r_d, r_e;
    logic [31:0]        r_w [16];
    logic [6:0]         r_round;
    logic [CNT_W-1:0]   r_remain;

    logic               w_full, w_pop, w_wr_ok, w_drop, w_avail, w_start_ok;
    logic [31:0]        w_a, w_b, w_c, w_d, w_e, w_tmp, w_new;
    logic [31:0]        w_win [16];
    logic [6:0]         w_t;
    logic [31:0]        w_hsum [5];

    assign w_full     = (r_count == c_LVL_W'(BUF_DEPTH));
    assign w_pop      = (r_state == c_ST_LOAD);
    assign w_wr_ok    = w_en && (!w_full || w_pop);
    assign w_drop     = w_en && !w_wr_ok;
    // A block arriving this cycle is poppable next cycle, so it counts as available.
    assign w_avail    = (r_count != '0) || w_wr_ok;
    assign w_start_ok = start && (r_state == c_ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if (block_num == '0)  w_next_state = c_ST_DONE;
                    else if (w_avail)     w_next_state = c_ST_LOAD;
                    else                  w_next_state = c_ST_WAIT;
                end
            end
            c_ST_WAIT:  if (w_avail) w_next_state = c_ST_LOAD;
            c_ST_LOAD:  w_next_state = c_ST_ROUND;
            c_ST_ROUND: if (r_round == c_LAST_STEP) w_next_state = c_ST_UPDATE;
            c_ST_UPDATE: begin
                if (r_remain == CNT_W'(1)) w_next_state = c_ST_DONE;
                else if (w_avail)          w_next_state = c_ST_LOAD;
                else                       w_next_state = c_ST_WAIT;
            end
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // UNROLL chained rounds; the window always holds W[t..t+15] with W[t] at index 0.
    always_comb begin
        w_a = r_a; w_b = r_b; w_c = r_c; w_d = r_d; w_e = r_e;
        w_win = r_w;
        w_t   = r_round;
        w_tmp = '0;
        w_new = '0;
        for (int i = 0; i < UNROLL; i++) begin
            w_t   = r_round + 7'(i);
            w_tmp = rotl(w_a, 5) + f_fn(w_t, w_b, w_c, w_d) + w_e + k_fn(w_t) + w_win[0];
            w_new = rotl(w_win[13] ^ w_win[8] ^ w_win[2] ^ w_win[0], 1);
            w_e = w_d;
            w_d = w_c;
            w_c = rotl(w_b, 30);
            w_b = w_a;
            w_a = w_tmp;
            for (int j = 0; j < 15; j++) w_win[j] = w_win[j+1];
            w_win[15] = w_new;
        end
    end

    always_comb begin
        w_hsum[0] = r_h[0] + r_a;
        w_hsum[1] = r_h[1] + r_b;
        w_hsum[2] = r_h[2] + r_c;
        w_hsum[3] = r_h[3] + r_d;
        w_hsum[4] = r_h[4] + r_e;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= msg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_hash     <= '0;
            r_h        <= '{default: '0};
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_e        <= '0;
            r_w        <= '{default: '0};
            r_round    <= '0;
            r_remain   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count    <= r_count + c_LVL_W'(w_wr_ok) - c_LVL_W'(w_pop);
            r_overflow <= (r_overflow && !w_start_ok) || w_drop;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_h[0]   <= c_IV[159:128];
                        r_h[1]   <= c_IV[127:96];
                        r_h[2]   <= c_IV[95:64];
                        r_h[3]   <= c_IV[63:32];
                        r_h[4]   <= c_IV[31:0];
                        r_remain <= block_num;
                        if (block_num == '0) r_hash <= c_IV;
                    end
                end
                c_ST_LOAD: begin
                    for (int j = 0; j < 16; j++) r_w[j] <= r_mem[r_rd_ptr][511-32*j -: 32];
                    r_a     <= r_h[0];
                    r_b     <= r_h[1];
                    r_c     <= r_h[2];
                    r_d     <= r_h[3];
                    r_e     <= r_h[4];
                    r_round <= '0;
                end
                c_ST_ROUND: begin
                    r_a     <= w_a;
                    r_b     <= w_b;
                    r_c     <= w_c;
                    r_d     <= w_d;
                    r_e     <= w_e;
                    r_w     <= w_win;
                    r_round <= r_round + 7'(UNROLL);
                end
                c_ST_UPDATE: begin
                    r_h      <= w_hsum;
                    r_remain <= r_remain - CNT_W'(1);
                    if (r_remain == CNT_W'(1))
                        r_hash <= {w_hsum[0], w_hsum[1], w_hsum[2], w_hsum[3], w_hsum[4]};
                end
                default: ;
            endcase
        end
    end

    assign full     = w_full;
    assign level    = r_count;
    assign busy     = (r_state != c_ST_IDLE);
    assign done     = (r_state == c_ST_DONE);
    assign hash     = r_hash;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
